// File: rtl/tone_pkg.sv
// Shared constants for the tone decoder: note frequency table, note codes and FSM states.
package tone_pkg;

  localparam int NOTE_CNT = 21;

  localparam logic [4:0] NOTE_SIL = 5'd0;
  localparam logic [4:0] NOTE_BAD = 5'd31;

  // low do..si, mid do..si, high do..si
  localparam int NOTE_HZ [1:NOTE_CNT] = '{
    131, 147, 165, 175, 196, 220, 247,
    262, 294, 330, 349, 392, 440, 494,
    523, 587, 659, 698, 784, 880, 988
  };

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_MATCH   = 2'd2
  } state_t;

  function automatic logic [23:0] note_period(input int clk_hz, input int idx);
    return 24'(clk_hz / NOTE_HZ[idx]);
  endfunction

endpackage

// File: rtl/tone_matcher.sv
// Sequential note search: one period-table entry per cycle over 21 cycles, then a done strobe
// with the first matching note code (NOTE_BAD when nothing is within tolerance).
module tone_matcher
  import tone_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] period,
  output logic        done,
  output logic [4:0]  code
);

  logic [23:0] period_tab [0:31];
  logic [23:0] meas_reg;
  logic [4:0]  idx_reg;
  logic        busy_reg;
  logic [4:0]  hit_reg, hit_next;
  logic        done_reg;
  logic [24:0] diff, abs_diff;
  logic        hit;

  // Unused slots stay zero so any index value is a legal read.
  for (genvar gi = 0; gi < 32; gi++) begin : g_tab
    if (gi >= 1 && gi <= NOTE_CNT) begin : g_note
      assign period_tab[gi] = note_period(CLK_HZ, gi);
    end else begin : g_pad
      assign period_tab[gi] = '0;
    end
  end

  always_comb begin
    diff     = {1'b0, meas_reg} - {1'b0, period_tab[idx_reg]};
    abs_diff = diff[24] ? (~diff + 25'd1) : diff;
    hit      = busy_reg && (abs_diff <= {6'd0, period_tab[idx_reg][23:5]});
    hit_next = hit_reg;
    if (hit && hit_reg == NOTE_BAD) hit_next = idx_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meas_reg <= '0;
      idx_reg  <= '0;
      busy_reg <= 1'b0;
      hit_reg  <= NOTE_BAD;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        meas_reg <= period;
        idx_reg  <= 5'd1;
        busy_reg <= 1'b1;
        hit_reg  <= NOTE_BAD;
      end else if (busy_reg) begin
        hit_reg <= hit_next;
        if (idx_reg == 5'(NOTE_CNT)) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end else begin
          idx_reg <= idx_reg + 5'd1;
        end
      end
    end
  end

  assign done = done_reg;
  assign code = hit_reg;

endmodule

// File: rtl/tone_decoder.sv
// Tone decoder top: synchroniser, period counter, FSM and note stability/silence tracking.
// Defining TONE_DEC_DURATION_EN adds dur_ms, the time the current note_code has been held.
module tone_decoder
  import tone_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int STABLE_CNT  = 3,
  parameter int SILENCE_CYC = 10_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tone_in,
  output logic [4:0]  note_code,
  output logic        note_valid,
  output logic        locked,
`ifdef TONE_DEC_DURATION_EN
  output logic [15:0] dur_ms,
`endif
  output logic [23:0] period_out
);

  localparam logic [23:0] SIL_LIMIT = 24'(SILENCE_CYC);
  localparam logic [3:0]  STABLE    = 4'(STABLE_CNT);

  logic [2:0]  sync_reg;
  logic        rise;
  logic [23:0] count_reg;
  logic        count_sat;
  state_t      state_reg, state_next;
  logic        capture, silence;
  logic        match_done;
  logic [4:0]  match_code;
  logic [4:0]  cand_reg, cand_next;
  logic [3:0]  stab_reg, stab_next;
  logic [4:0]  code_reg, code_next;
  logic        valid_reg, valid_next;
  logic        locked_reg;
  logic [23:0] period_reg;

  // Bits 0/1 form the synchroniser; bit 2 is the previous synchronised level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_reg <= '0;
    else        sync_reg <= {sync_reg[1:0], tone_in};
  end
  assign rise = sync_reg[1] & ~sync_reg[2];

  assign count_sat = (count_reg >= SIL_LIMIT);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          count_reg <= '0;
    else if (rise)       count_reg <= '0;
    else if (!count_sat) count_reg <= count_reg + 24'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (rise) state_next = ST_MEASURE;
      ST_MEASURE: if (rise) state_next = ST_MATCH;
                  else if (count_sat) state_next = ST_IDLE;
      ST_MATCH:   if (match_done) state_next = ST_MEASURE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    capture = 1'b0;
    silence = 1'b0;
    case (state_reg)
      ST_IDLE:    silence = count_sat && !rise;
      ST_MEASURE: begin
        capture = rise;
        silence = count_sat && !rise;
      end
      default: ;
    endcase
  end

  // The edge cycle itself counts, so the captured period is the edge-to-edge distance.
  tone_matcher #(.CLK_HZ(CLK_HZ)) u_matcher (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (capture),
    .period (count_reg + 24'd1),
    .done   (match_done),
    .code   (match_code)
  );

  always_comb begin
    cand_next = cand_reg;
    stab_next = stab_reg;
    code_next = code_reg;
    if (silence) begin
      cand_next = NOTE_SIL;
      stab_next = '0;
      code_next = NOTE_SIL;
    end else if (match_done) begin
      if (match_code == cand_reg) begin
        if (stab_reg != 4'hF) stab_next = stab_reg + 4'd1;
      end else begin
        cand_next = match_code;
        stab_next = 4'd1;
      end
      if (stab_next == STABLE && cand_next != code_reg) code_next = cand_next;
    end
    valid_next = (code_next != code_reg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_reg   <= NOTE_SIL;
      stab_reg   <= '0;
      code_reg   <= NOTE_SIL;
      valid_reg  <= 1'b0;
      locked_reg <= 1'b0;
      period_reg <= '0;
    end else begin
      cand_reg   <= cand_next;
      stab_reg   <= stab_next;
      code_reg   <= code_next;
      valid_reg  <= valid_next;
      locked_reg <= (code_next != NOTE_SIL) && (code_next != NOTE_BAD);
      if (capture) period_reg <= count_reg + 24'd1;
    end
  end

  assign note_code  = code_reg;
  assign note_valid = valid_reg;
  assign locked     = locked_reg;
  assign period_out = period_reg;

`ifdef TONE_DEC_DURATION_EN
  localparam logic [23:0] MS_DIV = 24'(CLK_HZ / 1000);

  logic [23:0] presc_reg;
  logic [15:0] dur_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg <= '0;
      dur_reg   <= '0;
    end else if (valid_next) begin
      presc_reg <= '0;
      dur_reg   <= '0;
    end else if (presc_reg == MS_DIV - 24'd1) begin
      presc_reg <= '0;
      if (dur_reg != 16'hFFFF) dur_reg <= dur_reg + 16'd1;
    end else begin
      presc_reg <= presc_reg + 24'd1;
    end
  end

  assign dur_ms = dur_reg;
`endif

endmodule

// File: tb/tb_tone_decoder.sv
// Scoreboard bench for tone_decoder: stimulus pushes expected note events, a monitor pops them on note_valid.
// Build with TONE_DEC_DURATION_EN defined to also exercise dur_ms.
module tb_tone_decoder;

  localparam int CLK_HZ = 200_000;
  localparam int STABLE = 3;
  localparam int SIL    = 3000;
  localparam int NOTE_FREQ [21] = '{
    131, 147, 165, 175, 196, 220, 247,
    262, 294, 330, 349, 392, 440, 494,
    523, 587, 659, 698, 784, 880, 988
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tone_in = 1'b0;
  logic [4:0]  note_code;
  logic        note_valid;
  logic        locked;
  logic [23:0] period_out;
`ifdef TONE_DEC_DURATION_EN
  logic [15:0] dur_ms;
`endif

  tone_decoder #(.CLK_HZ(CLK_HZ), .STABLE_CNT(STABLE), .SILENCE_CYC(SIL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tone_in    (tone_in),
    .note_code  (note_code),
    .note_valid (note_valid),
`ifdef TONE_DEC_DURATION_EN
    .dur_ms     (dur_ms),
`endif
    .locked     (locked),
    .period_out (period_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]  code;
    logic [23:0] period;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  int   last_edge = 0;
  int   last_pulse_cyc = 0;

  // Reference model state: recent match results, reported code, arming flag.
  int hist[$];
  int m_code  = 0;
  int m_last  = 0;
  bit m_armed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int classify(input int m);
    for (int i = 0; i < 21; i++) begin
      int p, d;
      p = CLK_HZ / NOTE_FREQ[i];
      d = (m > p) ? m - p : p - m;
      if (d <= p / 32) return i + 1;
    end
    return 31;
  endfunction

  // A note is reported once the last STABLE results agree and differ from the current code.
  task automatic model_capture(input int m);
    int   r;
    bit   run;
    exp_t e;
    r = classify(m);
    m_last = m;
    hist.push_back(r);
    if (hist.size() > STABLE) void'(hist.pop_front());
    run = (hist.size() == STABLE);
    foreach (hist[k]) if (hist[k] != r) run = 0;
    if (run && r != m_code) begin
      m_code = r;
      e.code = 5'(r);
      e.period = 24'(m);
      exp_q.push_back(e);
    end
  endtask

  task automatic model_edge();
    if (m_armed) model_capture(cyc - last_edge);
    else m_armed = 1;
    last_edge = cyc;
  endtask

  task automatic model_reset();
    hist.delete();
    exp_q.delete();
    m_code = 0;
    m_last = 0;
    m_armed = 0;
  endtask

  task automatic play(input int period, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      tone_in = 1'b1;
      model_edge();
      repeat (period / 2) @(posedge clk);
      #1 tone_in = 1'b0;
      repeat (period - period / 2 - 1) @(posedge clk);
    end
  endtask

  task automatic quiet();
    exp_t e;
    tone_in = 1'b0;
    if (m_code != 0) begin
      e.code = 5'd0;
      e.period = 24'(m_last);
      exp_q.push_back(e);
    end
    m_code = 0;
    hist.delete();
    m_armed = 0;
    repeat (SIL + 100) @(posedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_note_code"}, 32'(note_code), 32'd0);
    check({tag, "_note_valid"}, 32'(note_valid), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_period_out"}, 32'(period_out), 32'd0);
  endtask

  // Monitor: every note_valid pulse must match the next expected event.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (rst_n && prev_valid) check("pulse_width", 32'(note_valid), 32'd0);
    if (rst_n && note_valid && !prev_valid) begin
      exp_t e;
      pulses++;
      last_pulse_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got note_code %0d, expected no pulse", note_code);
      end else begin
        e = exp_q.pop_front();
        $display("pulse at cycle %0d: note_code=%0d period_out=%0d locked=%0d", cyc, note_code, period_out, locked);
        check("note_code", 32'(note_code), 32'(e.code));
        check("period_out", 32'(period_out), 32'(e.period));
        check("locked", 32'(locked), 32'(e.code != 0 && e.code != 31));
        if (e.code != 0) begin
          checks++;
          if (cyc - last_edge < 24 || cyc - last_edge > 26) begin
            errors++;
            $display("FAIL latency: got %0d cycles after edge, expected 24..26", cyc - last_edge);
          end
        end
      end
    end
    prev_valid = rst_n && note_valid;
  end

  initial begin
    repeat (150_000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with idle line, then 15 ms of silence.
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
`ifdef TONE_DEC_DURATION_EN
    check("reset_dur_ms", 32'(dur_ms), 32'd0);
`endif
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (15 * CLK_HZ / 1000) @(posedge clk);
    @(negedge clk);
    check("idle_pulses", 32'(pulses), 32'd0);
    check("idle_note_code", 32'(note_code), 32'd0);

    // Lock on la, switch to high do, drift to an off-tune 460 Hz.
    play(CLK_HZ / 440, 4);
    play(CLK_HZ / 523, 4);
    play(CLK_HZ / 460, 4);

    // Alternating la/si never stabilises; then silence.
    for (int k = 0; k < 4; k++) begin
      play(CLK_HZ / 440, 1);
      play(CLK_HZ / 494, 1);
    end
    quiet();

    // Tolerance edge of la: P + (P>>5) hits, one more cycle misses.
    play(454 + 454 / 32, 4);
    play(454 + 454 / 32 + 1, 4);
    play(454 - 454 / 32, 4);
    quiet();

    // Randomised segments: table notes with jitter, arbitrary periods, silences.
    for (int s = 0; s < 6; s++) begin
      int kind, n, p, j;
      kind = int'($urandom_range(0, 4));
      n = int'($urandom_range(2, 4));
      if (kind == 4) quiet();
      if (kind == 3) begin
        p = int'($urandom_range(202, 1526));
      end else begin
        p = CLK_HZ / NOTE_FREQ[$urandom_range(0, 20)];
        j = p / 64;
        p = p + int'($urandom_range(0, 2 * j)) - j;
      end
      play(p, n);
    end
    quiet();

    // Reset in the middle of a search that would have reported high do.
    play(CLK_HZ / 440, 4);
    play(CLK_HZ / 523, 3);
    @(posedge clk); #1 tone_in = 1'b1;
    repeat (12) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_zero("mid_match_reset");
    model_reset();
    tone_in = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    play(CLK_HZ / 440, 4);

`ifdef TONE_DEC_DURATION_EN
    fork
      play(CLK_HZ / 440, 23);
      begin
        while (cyc < last_pulse_cyc + 50 * CLK_HZ / 1000) @(negedge clk);
        checks++;
        if (dur_ms < 16'd49 || dur_ms > 16'd51) begin
          errors++;
          $display("FAIL dur_ms: got %0d, expected 49..51", dur_ms);
        end
      end
    join
`endif
    quiet();

    repeat (50) @(posedge clk);
    check("leftover_expected", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
